// File: rtl/ifetch_req_pkg.sv
// Shared types for the instruction-fetch requester: ibus request/response
// bundles, fetch FSM states and the default boot PC.
package ifetch_req_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_req.sv
// Instruction-fetch requester: one outstanding ibus read, single-entry output
// slot toward fetch, with stall and redirect handling (late responses drained).
//
//   state  | meaning
//   S_REQ  | idle; issues a read of pc_q whenever the output slot is free
//   S_WAIT | read of req_addr_q outstanding; response will be delivered
//   S_DROP | read outstanding but redirected; response will be discarded
module ifetch_req
  import ifetch_req_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  ifetch_state_t state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [63:0]   out_pc_q, out_pc_d;
  logic [31:0]   out_instr_q, out_instr_d;

  ibus_req_t     req;
  ibus_resp_t    resp;
  logic          slot_free;
  logic          rsp_seen;
  logic          complete;

  assign resp      = '{data_ok: iresp_data_ok, data: iresp_data};
  assign slot_free = !out_valid_q || !stall;
  // A response only counts while a request is actually on the bus.
  assign rsp_seen  = req.valid && resp.data_ok;
  assign complete  = rsp_seen && (state_q != S_DROP) && !redirect_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      pc_q        <= PC_RESET;
      req_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (req.valid && !resp.data_ok) state_d = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (resp.data_ok)       state_d = S_REQ;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (resp.data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    req.valid = 1'b1;
    req.addr  = req_addr_q;
    if (state_q == S_REQ) begin
      req.valid = slot_free;
      req.addr  = pc_q;
    end
  end

  // Bus is quiet while held in reset even though the reset state is S_REQ.
  assign ireq_valid = req.valid && resetn;
  assign ireq_addr  = req.addr;

  always_comb begin
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    if (state_q == S_REQ && req.valid) req_addr_d = pc_q;

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
    end else if (complete) begin
      pc_d        = req.addr + 64'(PC_STEP);
      out_valid_d = 1'b1;
      out_pc_d    = req.addr;
      out_instr_d = resp.data;
    end else if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

endmodule

// File: tb/tb_ifetch_req.sv
// Directed bench for ifetch_req: sequential fetch, zero-wait, stall, redirect
// during wait / with stalled output, PC wrap and reset mid-wait.
module tb_ifetch_req;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_errors = 0;

  ifetch_req dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One fetch of address a returning word d, data_ok lat cycles after issue.
  // Starts in the issue cycle, ends in the cycle after data_ok.
  task automatic xact(input logic [63:0] a, input logic [31:0] d, input int lat);
    iresp_data_ok = (lat == 0);
    iresp_data    = d;
    #1;
    chk("issue_valid", ireq_valid, 1);
    chk("issue_addr", ireq_addr, a);
    for (int i = 1; i <= lat; i++) begin
      cyc();
      iresp_data_ok = (i == lat);
      #1;
      chk("hold_valid", ireq_valid, 1);
      chk("hold_addr", ireq_addr, a);
      chk("wait_out_valid", out_valid, 0);
    end
    cyc();
    iresp_data_ok = 1'b0;
    iresp_data    = 32'h0;
    #1;
    chk("out_valid", out_valid, 1);
    chk("out_pc", out_pc, a);
    chk("out_instr", out_instr, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn         = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    stall          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    resetn = 1'b1;

    // sequential fetch, 2-cycle memory
    xact(64'h8000_0000, 32'h0000_0013, 2);
    xact(64'h8000_0004, 32'h0010_0093, 2);
    xact(64'h8000_0008, 32'h0020_0113, 2);

    // zero-wait memory: a completion every cycle
    xact(64'h8000_000C, 32'h1111_1111, 0);
    xact(64'h8000_0010, 32'h2222_2222, 0);
    xact(64'h8000_0014, 32'h3333_3333, 0);

    // hold a valid output under stall for 5 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ireq_valid", ireq_valid, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_pc", out_pc, 64'h8000_0014);
      chk("stall_out_instr", out_instr, 32'h3333_3333);
      cyc();
    end
    stall = 1'b0;
    xact(64'h8000_0018, 32'h4444_4444, 2);

    // redirect during WAIT; late response drained and dropped
    #1;
    chk("rdw_issue_addr", ireq_addr, 64'h8000_001C);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    #1;
    chk("rdw_addr_c1", ireq_addr, 64'h8000_001C);
    cyc();
    redirect_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      iresp_data_ok = (i == 4);
      iresp_data    = 32'hDEAD_BEEF;
      #1;
      chk("rdw_drop_valid", ireq_valid, 1);
      chk("rdw_drop_addr", ireq_addr, 64'h8000_001C);
      chk("rdw_drop_out_valid", out_valid, 0);
      cyc();
    end
    iresp_data_ok = 1'b0;
    #1;
    chk("rdw_after_out_valid", out_valid, 0);
    chk("rdw_next_addr", ireq_addr, 64'h8000_1000);
    xact(64'h8000_1000, 32'h5555_5555, 1);

    // redirect + data_ok + stalled valid output in one cycle
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'hBAD0_BAD0;
    #1;
    chk("rds_ireq_valid", ireq_valid, 0);
    cyc();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    #1;
    chk("rds_out_valid", out_valid, 0);
    chk("rds_out_instr_kept", out_instr, 32'h5555_5555);
    xact(64'h8000_2000, 32'h6666_6666, 2);

    // redirect coinciding with a zero-wait completion toward the top of memory
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'h7777_7777;
    #1;
    chk("rdz_issue_addr", ireq_addr, 64'h8000_2004);
    cyc();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    #1;
    chk("rdz_out_valid", out_valid, 0);
    xact(64'hFFFF_FFFF_FFFF_FFFC, 32'h8888_8888, 1);

    // wrap to 0, then reset mid-WAIT
    #1;
    chk("wrap_addr", ireq_addr, 64'h0);
    chk("wrap_valid", ireq_valid, 1);
    cyc();
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_ireq_valid", ireq_valid, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_pc", out_pc, 0);
    chk("midrst_out_instr", out_instr, 0);
    cyc();
    resetn = 1'b1;
    xact(64'h8000_0000, 32'h9999_9999, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
